// File: rtl/mac_issue_sb_pkg.sv
// mac_issue_sb_pkg: shared decode/scoreboard types and MAC pipeline depth
package mac_issue_sb_pkg;

    localparam int XLEN    = 32;
    localparam int TAG_W   = XLEN;
    localparam int MAC_LAT = 4;

    typedef struct packed {
        logic             mac;
        logic             legal;
        logic             nop;
        logic [4:0]       rs1_addr;
        logic [4:0]       rs2_addr;
        logic [4:0]       rd_addr;
        logic [TAG_W-1:0] instr_tag;
    } idu1_out_t;

    typedef struct packed {
        logic             v;
        logic [4:0]       rd;
        logic [TAG_W-1:0] tag;
    } mac_sb_entry_t;

    function automatic logic [2:0] count_valid(input mac_sb_entry_t [MAC_LAT-1:0] e);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < MAC_LAT; k++) n = n + 3'(e[k].v);
        return n;
    endfunction

endpackage

// File: rtl/mac_issue_sb_hazard.sv
// mac_sb_hazard: RAW/WAW comparator of pending MAC destinations against the decoded instr
module mac_sb_hazard
    import mac_issue_sb_pkg::*;
(
    input  mac_sb_entry_t [MAC_LAT-1:0] entries,
    input  logic                        live,
    input  logic                        is_mac,
    input  logic [4:0]                  rs1_addr,
    input  logic [4:0]                  rs2_addr,
    input  logic [4:0]                  rd_addr,
    output logic                        raw,
    output logic                        waw
);

    // rd=0 entries never conflict; MAC-to-MAC dependence is forwarded inside the MAC
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int k = 0; k < MAC_LAT; k++) begin
            if (entries[k].v && entries[k].rd != 5'd0) begin
                raw = raw | (live & (entries[k].rd == rs1_addr || entries[k].rd == rs2_addr));
                waw = waw | (live & ~is_mac & (entries[k].rd == rd_addr));
            end
        end
    end

endmodule

// File: rtl/mac_issue_sb.sv
// mac_issue_sb: issue gate and write-back scoreboard for the 4-stage MAC pipeline
module mac_issue_sb
    import mac_issue_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  idu1_out_t        idu1_ctrl,
    output idu1_out_t        mac_ctrl,
    output logic             stall_req,
    input  logic [4:0]       mac_wb_rd_addr,
    input  logic             mac_wb_wr_en,
    input  logic [TAG_W-1:0] mac_wb_tag,
    output logic [2:0]       inflight_cnt,
    output logic             sb_err
);

    mac_sb_entry_t [MAC_LAT-1:0] entries_q, entries_d;
    logic [2:0] inflight_q, inflight_d;
    logic       sb_err_q, sb_err_d;
    logic       live, is_mac, issue, raw, waw, wb_err;
    mac_sb_entry_t last;

    mac_sb_hazard u_hazard (
        .entries  (entries_q),
        .live     (live),
        .is_mac   (is_mac),
        .rs1_addr (idu1_ctrl.rs1_addr),
        .rs2_addr (idu1_ctrl.rs2_addr),
        .rd_addr  (idu1_ctrl.rd_addr),
        .raw      (raw),
        .waw      (waw)
    );

    // Issue gating and write-back comparison against the oldest entry
    always_comb begin
        live      = idu1_ctrl.legal & ~idu1_ctrl.nop;
        is_mac    = idu1_ctrl.mac & live;
        stall_req = live & (raw | waw);
        issue     = is_mac & ~stall_req;
        mac_ctrl  = issue ? idu1_ctrl : '0;
        last      = entries_q[MAC_LAT-1];
        wb_err    = (last.v != mac_wb_wr_en) |
                    (last.v & mac_wb_wr_en & ((last.rd != mac_wb_rd_addr) | (last.tag != mac_wb_tag)));
    end

    // Shift the scoreboard in lockstep with the MAC stages unless frozen
    always_comb begin
        entries_d  = entries_q;
        inflight_d = inflight_q;
        sb_err_d   = sb_err_q;
        if (!freeze) begin
            for (int k = MAC_LAT-1; k > 0; k--) entries_d[k] = entries_q[k-1];
            entries_d[0] = '{v: issue, rd: idu1_ctrl.rd_addr, tag: idu1_ctrl.instr_tag};
            inflight_d   = count_valid(entries_d);
            sb_err_d     = sb_err_q | wb_err;
        end
    end

    // State registers; the MAC is reset together with us, so reset drops everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries_q  <= '0;
            inflight_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            inflight_q <= inflight_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign inflight_cnt = inflight_q;
    assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_mac_issue_sb.sv
// tb_mac_issue_sb: table-driven cycle vectors for the MAC issue scoreboard
module tb_mac_issue_sb;
    import mac_issue_sb_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n, freeze, mac_wb_wr_en, stall_req, sb_err;
    idu1_out_t        idu1_ctrl, mac_ctrl;
    logic [4:0]       mac_wb_rd_addr;
    logic [TAG_W-1:0] mac_wb_tag;
    logic [2:0]       inflight_cnt;

    int checks = 0;
    int errors = 0;

    mac_issue_sb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .idu1_ctrl      (idu1_ctrl),
        .mac_ctrl       (mac_ctrl),
        .stall_req      (stall_req),
        .mac_wb_rd_addr (mac_wb_rd_addr),
        .mac_wb_wr_en   (mac_wb_wr_en),
        .mac_wb_tag     (mac_wb_tag),
        .inflight_cnt   (inflight_cnt),
        .sb_err         (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        idu1_out_t        c;
        logic             frz;
        logic             rstn;
        logic             wen;
        logic [4:0]       wrd;
        logic [TAG_W-1:0] wtag;
        logic             e_stall;
        logic             e_iss;
        logic [2:0]       e_cnt;
        logic             e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic idu1_out_t mk(logic m, logic l, logic n, logic [4:0] r1, logic [4:0] r2,
                                     logic [4:0] rd, logic [TAG_W-1:0] t);
        idu1_out_t c;
        c.mac = m; c.legal = l; c.nop = n;
        c.rs1_addr = r1; c.rs2_addr = r2; c.rd_addr = rd; c.instr_tag = t;
        return c;
    endfunction

    function automatic idu1_out_t idle();
        return mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    endfunction

    function automatic idu1_out_t mac(logic [4:0] rd, logic [TAG_W-1:0] t);
        return mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, rd, t);
    endfunction

    function automatic idu1_out_t alu(logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
        return mk(1'b0, 1'b1, 1'b0, r1, r2, rd, 32'hA0);
    endfunction

    // one row = one clock cycle; expected cnt/err are the registered values before that cycle's edge
    function automatic void add(idu1_out_t c, logic frz, logic rstn, logic wen, logic [4:0] wrd,
                                logic [TAG_W-1:0] wtag, logic s, logic i, logic [2:0] cnt, logic err);
        vec_t v;
        v.c = c; v.frz = frz; v.rstn = rstn; v.wen = wen; v.wrd = wrd; v.wtag = wtag;
        v.e_stall = s; v.e_iss = i; v.e_cnt = cnt; v.e_err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int row, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    task automatic idle_n(int n, logic [2:0] cnt, logic err);
        for (int i = 0; i < n; i++) add(idle(), 0, 1, 0, 0, 0, 0, 0, cnt, err);
    endtask

    initial begin
        // 1: single MAC, aligned write-back
        add(mac(5, 1), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        idle_n(3, 1, 0);
        add(idle(), 0, 1, 1, 5, 1, 0, 0, 1, 0);
        idle_n(1, 0, 0);
        // 2: RAW stall for four cycles
        add(mac(7, 2), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add(alu(7, 0, 1), 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(alu(7, 0, 1), 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(alu(7, 0, 1), 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(alu(7, 0, 1), 0, 1, 1, 7, 2, 1, 0, 1, 0);
        add(alu(7, 0, 1), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // 3: four back-to-back MACs to the same rd
        for (int i = 0; i < 4; i++) add(mac(3, 10 + i), 0, 1, 0, 0, 0, 0, 1, 3'(i), 0);
        for (int i = 0; i < 4; i++) add(idle(), 0, 1, 1, 3, 10 + i, 0, 0, 3'(4 - i), 0);
        idle_n(1, 0, 0);
        // 7: WAW stall from a non-MAC writing the same rd
        add(mac(4, 20), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add(alu(1, 2, 4), 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(alu(1, 2, 4), 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(alu(1, 2, 4), 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(alu(1, 2, 4), 0, 1, 1, 4, 20, 1, 0, 1, 0);
        add(alu(1, 2, 4), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // 8: MAC marked nop is not issued nor tracked
        add(mk(1, 1, 1, 0, 0, 5, 77), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(alu(5, 0, 1), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // rd=0 MAC is tracked but never stalls
        add(mac(0, 30), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add(alu(0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 1, 0);
        idle_n(2, 1, 0);
        add(idle(), 0, 1, 1, 0, 30, 0, 0, 1, 0);
        idle_n(1, 0, 0);
        // 4: freeze mid-flight; stall still visible, bogus write-back ignored
        add(mac(6, 40), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        idle_n(1, 1, 0);
        add(alu(6, 0, 1), 1, 1, 1, 9, 99, 1, 0, 1, 0);
        add(idle(), 1, 1, 1, 9, 99, 0, 0, 1, 0);
        add(idle(), 1, 1, 1, 9, 99, 0, 0, 1, 0);
        idle_n(2, 1, 0);
        add(idle(), 0, 1, 1, 6, 40, 0, 0, 1, 0);
        idle_n(1, 0, 0);
        // 5: spurious write-back sets sticky error
        add(idle(), 0, 1, 1, 5, 1, 0, 0, 0, 0);
        idle_n(2, 0, 1);
        // 6: reset with three MACs in flight
        add(mac(8, 50), 0, 1, 0, 0, 0, 0, 1, 0, 1);
        add(mac(9, 51), 0, 1, 0, 0, 0, 0, 1, 1, 1);
        add(mac(10, 52), 0, 1, 0, 0, 0, 0, 1, 2, 1);
        add(alu(8, 0, 1), 0, 0, 0, 0, 0, 1, 0, 3, 1);
        add(alu(8, 0, 1), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // 5: tag mismatch (expect 9, drive 8)
        add(mac(9, 9), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        idle_n(2, 1, 0);
        add(idle(), 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(idle(), 0, 1, 1, 9, 8, 0, 0, 1, 0);
        idle_n(2, 0, 1);
        // missing write-back for a valid entry
        add(idle(), 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(mac(2, 60), 0, 1, 0, 0, 0, 0, 1, 0, 0);
        idle_n(2, 1, 0);
        add(idle(), 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(idle(), 0, 1, 0, 2, 60, 0, 0, 1, 0);
        idle_n(1, 0, 1);

        rst_n = 1'b0; freeze = 1'b0; idu1_ctrl = idle();
        mac_wb_wr_en = 1'b0; mac_wb_rd_addr = '0; mac_wb_tag = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("reset_cnt", -1, 64'(inflight_cnt), 64'd0);
        chk("reset_err", -1, 64'(sb_err), 64'd0);
        chk("reset_stall", -1, 64'(stall_req), 64'd0);
        chk("reset_mac_ctrl", -1, 64'(mac_ctrl), 64'd0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            idu1_ctrl      = vecs[r].c;
            freeze         = vecs[r].frz;
            rst_n          = vecs[r].rstn;
            mac_wb_wr_en   = vecs[r].wen;
            mac_wb_rd_addr = vecs[r].wrd;
            mac_wb_tag     = vecs[r].wtag;
            #2;
            chk("stall_req", r, 64'(stall_req), 64'(vecs[r].e_stall));
            chk("mac_ctrl", r, 64'(mac_ctrl), vecs[r].e_iss ? 64'(vecs[r].c) : 64'd0);
            chk("inflight_cnt", r, 64'(inflight_cnt), 64'(vecs[r].e_cnt));
            chk("sb_err", r, 64'(sb_err), 64'(vecs[r].e_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
